// File: rtl/token_scan_fsm_if.sv
// Character stream in, completed-token reports out, for token_scan_fsm.
// The source side drives the master modport; the scanner uses the slave modport.
interface token_scan_fsm_if #(
  parameter int LEN_W = 5
);
  // in_valid qualifies char/eos for one cycle. There is no backpressure: a
  // presented char is always consumed. tok_valid is a one-cycle pulse, and
  // tok_kind/tok_len are meaningful only while it is high.
  logic             in_valid;
  logic [7:0]       char;
  logic             eos;
  logic             tok_valid;
  logic [1:0]       tok_kind;
  logic [LEN_W-1:0] tok_len;

  modport master (
    output in_valid, char, eos,
    input  tok_valid, tok_kind, tok_len
  );

  modport slave (
    input  in_valid, char, eos,
    output tok_valid, tok_kind, tok_len
  );
endinterface

// File: rtl/token_scan_fsm.sv
// Streaming tokenizer: splits chars at delimiters and classifies each token as
// identifier, decimal number or bad, with a registered one-cycle report.
module token_scan_fsm #(
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  parameter int ALLOW_US = 1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  token_scan_fsm_if.slave   bus,
  output logic              in_id,
  output logic [CNT_W-1:0]  id_cnt,
  output logic [CNT_W-1:0]  bad_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IDENT  = 2'd1,
    S_NUMBER = 2'd2,
    S_BAD    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_L = 2'd0,
    C_D = 2'd1,
    C_S = 2'd2,
    C_X = 2'd3
  } cls_e;

  localparam logic [1:0]       KIND_NONE = 2'b00;
  localparam logic [1:0]       KIND_ID   = 2'b01;
  localparam logic [1:0]       KIND_NUM  = 2'b10;
  localparam logic [1:0]       KIND_BAD  = 2'b11;
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tok_valid_q, tok_valid_d;
  logic [1:0]       tok_kind_q, tok_kind_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             in_id_q, in_id_d;
  logic [CNT_W-1:0] id_cnt_q, id_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;

  cls_e             cls;
  state_e           grown_state;
  logic [LEN_W-1:0] grown_len;
  logic             close;

  always_comb begin
    cls = C_X;
    if ((bus.char >= 8'h41 && bus.char <= 8'h5A) ||
        (bus.char >= 8'h61 && bus.char <= 8'h7A)) begin
      cls = C_L;
    end else if (bus.char == 8'h5F && ALLOW_US != 0) begin
      cls = C_L;
    end else if (bus.char >= 8'h30 && bus.char <= 8'h39) begin
      cls = C_D;
    end else if (bus.char == 8'h20 || bus.char == 8'h09 || bus.char == 8'h0A ||
                 bus.char == 8'h0D || bus.char == 8'h3B) begin
      cls = C_S;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  // Next state: a non-delimiter char is absorbed first, so an eos arriving
  // with it closes a token that already includes that char.
  always_comb begin
    grown_state = state_q;
    grown_len   = len_q;
    if (bus.in_valid && cls != C_S) begin
      if (len_q == LEN_MAX) begin
        grown_state = S_BAD;
        grown_len   = LEN_MAX;
      end else begin
        grown_len = len_q + 1'b1;
        case (state_q)
          S_IDLE: begin
            if (cls == C_L)      grown_state = S_IDENT;
            else if (cls == C_D) grown_state = S_NUMBER;
            else                 grown_state = S_BAD;
          end
          S_IDENT:  grown_state = (cls == C_X) ? S_BAD : S_IDENT;
          S_NUMBER: grown_state = (cls == C_D) ? S_NUMBER : S_BAD;
          default:  grown_state = S_BAD;
        endcase
      end
    end
    close   = (bus.eos || (bus.in_valid && cls == C_S)) && (grown_state != S_IDLE);
    state_d = close ? S_IDLE : grown_state;
    len_d   = close ? '0 : grown_len;
  end

  // Outputs
  always_comb begin
    tok_valid_d = close;
    tok_kind_d  = KIND_NONE;
    tok_len_d   = '0;
    id_cnt_d    = id_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    in_id_d     = (state_d == S_IDENT);
    if (close) begin
      tok_len_d = grown_len;
      case (grown_state)
        S_IDENT:  tok_kind_d = KIND_ID;
        S_NUMBER: tok_kind_d = KIND_NUM;
        default:  tok_kind_d = KIND_BAD;
      endcase
      if (grown_state == S_IDENT && id_cnt_q != CNT_MAX) begin
        id_cnt_d = id_cnt_q + 1'b1;
      end
      if (grown_state == S_BAD && bad_cnt_q != CNT_MAX) begin
        bad_cnt_d = bad_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_valid_q <= 1'b0;
      tok_kind_q  <= KIND_NONE;
      tok_len_q   <= '0;
      in_id_q     <= 1'b0;
      id_cnt_q    <= '0;
      bad_cnt_q   <= '0;
    end else begin
      tok_valid_q <= tok_valid_d;
      tok_kind_q  <= tok_kind_d;
      tok_len_q   <= tok_len_d;
      in_id_q     <= in_id_d;
      id_cnt_q    <= id_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign bus.tok_valid = tok_valid_q;
  assign bus.tok_kind  = tok_kind_q;
  assign bus.tok_len   = tok_len_q;
  assign in_id         = in_id_q;
  assign id_cnt        = id_cnt_q;
  assign bad_cnt       = bad_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_token_scan_fsm.sv
// Bench for token_scan_fsm: two instances (underscore-as-letter with 8-bit counters,
// underscore-illegal with 2-bit counters) share one stimulus and one token model.
module tb_token_scan_fsm;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  token_scan_fsm_if #(.LEN_W(LEN_W)) bus0 ();
  token_scan_fsm_if #(.LEN_W(LEN_W)) bus1 ();

  logic       in_id0, in_id1;
  logic [7:0] id_cnt0, bad_cnt0;
  logic [1:0] id_cnt1, bad_cnt1;
  logic [1:0] dbg0, dbg1;

  token_scan_fsm #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .ALLOW_US(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .in_id(in_id0),
    .id_cnt(id_cnt0), .bad_cnt(bad_cnt0), .dbg_state(dbg0)
  );

  token_scan_fsm #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .ALLOW_US(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .in_id(in_id1),
    .id_cnt(id_cnt1), .bad_cnt(bad_cnt1), .dbg_state(dbg1)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Token text is the same for both instances; only classification and
  // counter saturation differ between them.
  logic [7:0] tok_q[$];
  int exp_valid, exp_len;
  int exp_kind[2], exp_in_id[2], exp_id_cnt[2], exp_bad_cnt[2];
  int cnt_max[2] = '{255, 3};
  bit allow_us[2] = '{1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_delim(logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == 8'h3B;
  endfunction

  function automatic bit is_digit(logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  function automatic bit is_letter(logic [7:0] c, bit us);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) || (us && c == 8'h5F);
  endfunction

  function automatic bit tok_is_ident(bit us);
    if (tok_q.size() == 0 || tok_q.size() > MAX_LEN) return 1'b0;
    if (!is_letter(tok_q[0], us)) return 1'b0;
    foreach (tok_q[i]) if (!is_letter(tok_q[i], us) && !is_digit(tok_q[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int tok_class(bit us);
    if (tok_q.size() > MAX_LEN) return 3;
    if (tok_is_ident(us)) return 1;
    foreach (tok_q[i]) if (!is_digit(tok_q[i])) return 3;
    return 2;
  endfunction

  task automatic model_reset();
    tok_q.delete();
    exp_valid = 0;
    exp_len   = 0;
    for (int k = 0; k < 2; k++) begin
      exp_kind[k] = 0; exp_in_id[k] = 0; exp_id_cnt[k] = 0; exp_bad_cnt[k] = 0;
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] c, input bit e);
    exp_valid = 0;
    exp_len   = 0;
    for (int k = 0; k < 2; k++) exp_kind[k] = 0;
    if (v && !is_delim(c)) tok_q.push_back(c);
    if (((v && is_delim(c)) || e) && tok_q.size() > 0) begin
      exp_valid = 1;
      exp_len   = (tok_q.size() > MAX_LEN) ? MAX_LEN : tok_q.size();
      for (int k = 0; k < 2; k++) begin
        exp_kind[k] = tok_class(allow_us[k]);
        if (exp_kind[k] == 1 && exp_id_cnt[k] < cnt_max[k]) exp_id_cnt[k]++;
        if (exp_kind[k] == 3 && exp_bad_cnt[k] < cnt_max[k]) exp_bad_cnt[k]++;
      end
      tok_q.delete();
    end
    for (int k = 0; k < 2; k++) exp_in_id[k] = tok_is_ident(allow_us[k]);
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input bit e);
    bus0.in_valid = v; bus0.char = c; bus0.eos = e;
    bus1.in_valid = v; bus1.char = c; bus1.eos = e;
  endtask

  task automatic step(input bit v, input logic [7:0] c, input bit e);
    @(negedge clk);
    drive(v, c, e);
    @(posedge clk);
    model_step(v, c, e);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
  endtask

  task automatic send_rep(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) step(1'b1, c, 1'b0);
  endtask

  // Per-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("tok_valid0", 32'(bus0.tok_valid), 32'(exp_valid));
        check("tok_kind0",  32'(bus0.tok_kind),  32'(exp_kind[0]));
        check("tok_len0",   32'(bus0.tok_len),   32'(exp_len));
        check("in_id0",     32'(in_id0),         32'(exp_in_id[0]));
        check("id_cnt0",    32'(id_cnt0),        32'(exp_id_cnt[0]));
        check("bad_cnt0",   32'(bad_cnt0),       32'(exp_bad_cnt[0]));
        check("tok_valid1", 32'(bus1.tok_valid), 32'(exp_valid));
        check("tok_kind1",  32'(bus1.tok_kind),  32'(exp_kind[1]));
        check("tok_len1",   32'(bus1.tok_len),   32'(exp_len));
        check("in_id1",     32'(in_id1),         32'(exp_in_id[1]));
        check("id_cnt1",    32'(id_cnt1),        32'(exp_id_cnt[1]));
        check("bad_cnt1",   32'(bad_cnt1),       32'(exp_bad_cnt[1]));
      end
    end
  end

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_tok_valid", 32'(bus0.tok_valid), 32'd0);
    check("rst_tok_kind",  32'(bus0.tok_kind),  32'd0);
    check("rst_tok_len",   32'(bus0.tok_len),   32'd0);
    check("rst_in_id",     32'(in_id0),         32'd0);
    check("rst_id_cnt",    32'(id_cnt0),        32'd0);
    check("rst_bad_cnt",   32'(bad_cnt0),       32'd0);
    check("rst_state",     32'(dbg0),           32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Identifier
    step(1'b1, "a", 1'b0);
    #1 check("lit_in_id_first", 32'(in_id0), 32'd1);
    send_str("bcd1234");
    #1 check("lit_in_id_last", 32'(in_id0), 32'd1);
    step(1'b1, " ", 1'b0);
    #1;
    check("lit_id_valid", 32'(bus0.tok_valid), 32'd1);
    check("lit_id_kind",  32'(bus0.tok_kind),  32'd1);
    check("lit_id_len",   32'(bus0.tok_len),   32'd8);
    check("lit_id_cnt",   32'(id_cnt0),        32'd1);
    check("lit_id_in_id", 32'(in_id0),         32'd0);

    // Number, then letter inside a number
    send_str("123;");
    #1;
    check("lit_num_kind", 32'(bus0.tok_kind), 32'd2);
    check("lit_num_len",  32'(bus0.tok_len),  32'd3);
    send_str("12a ");
    #1;
    check("lit_bad_kind", 32'(bus0.tok_kind), 32'd3);
    check("lit_bad_len",  32'(bus0.tok_len),  32'd3);
    check("lit_bad_cnt",  32'(bad_cnt0),      32'd1);

    // Length boundary: exactly MAX_LEN is legal, one more is overlong
    send_rep("y", 16);
    #1 check("lit_in_id_16", 32'(in_id0), 32'd1);
    step(1'b1, " ", 1'b0);
    #1;
    check("lit_16_kind", 32'(bus0.tok_kind), 32'd1);
    check("lit_16_len",  32'(bus0.tok_len),  32'd16);
    send_rep("x", 17);
    #1 check("lit_in_id_17", 32'(in_id0), 32'd0);
    step(1'b1, " ", 1'b0);
    #1;
    check("lit_17_kind", 32'(bus0.tok_kind), 32'd3);
    check("lit_17_len",  32'(bus0.tok_len),  32'd16);

    // Underscore handling, closed by eos
    send_str("_v2");
    step(1'b0, 8'h00, 1'b1);
    #1;
    check("lit_us1_kind", 32'(bus0.tok_kind), 32'd1);
    check("lit_us1_len",  32'(bus0.tok_len),  32'd3);
    check("lit_us0_kind", 32'(bus1.tok_kind), 32'd3);
    check("lit_us0_len",  32'(bus1.tok_len),  32'd3);

    // Bubbles, then final char together with eos
    step(1'b1, "a", 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, "b", 1'b0);
    step(1'b0, "z", 1'b0);
    step(1'b1, "9", 1'b1);
    #1;
    check("lit_eos_kind", 32'(bus0.tok_kind), 32'd1);
    check("lit_eos_len",  32'(bus0.tok_len),  32'd3);
    step(1'b0, 8'h00, 1'b1);
    #1 check("lit_eos_idle", 32'(bus0.tok_valid), 32'd0);
    send_str("  ;");
    #1 check("lit_delims", 32'(bus0.tok_valid), 32'd0);

    // Back-to-back tokens, eos with a delimiter, lone illegal chars
    send_str("a b\tc\r\n4;");
    send_str("ab");
    step(1'b1, " ", 1'b1);
    step(1'b0, 8'h00, 1'b0);
    send_str("# %% @x ");
    for (int i = 0; i < 4; i++) send_str("q ");
    #1;
    check("lit_id_sat1",  32'(id_cnt1),  32'd3);
    check("lit_bad_sat1", 32'(bad_cnt1), 32'd3);

    // Reset in the middle of a token
    send_str("abc");
    #3;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    model_reset();
    #1;
    check("lit_mrst_valid", 32'(bus0.tok_valid), 32'd0);
    check("lit_mrst_in_id", 32'(in_id0),         32'd0);
    check("lit_mrst_idcnt", 32'(id_cnt0),        32'd0);
    check("lit_mrst_bad",   32'(bad_cnt0),       32'd0);
    check("lit_mrst_state", 32'(dbg0),           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, " ", 1'b0);
    #1 check("lit_post_rst", 32'(bus0.tok_valid), 32'd0);
    send_str("ok ");
    #1 check("lit_post_idcnt", 32'(id_cnt0), 32'd1);

    repeat (3) step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/token_scan_fsm.md
Name: token_scan_fsm

Overview:
- Streaming character-class recognizer: one 8-bit ASCII char per accepted cycle; splits the stream into tokens at delimiters.
- Classifies each token as identifier, decimal number or bad, and reports kind and length.
- Generalises the single-output identifier FSM with valid qualification, configurable length limit, underscore mode, flush and running statistics.
- Sits between a char source (UART RX / testbench ROM) and downstream parser logic.

Parameters:
- MAX_LEN, 16: longest legal token; longer tokens are reported BAD.
- LEN_W, 5: width of tok_len; must satisfy MAX_LEN <= 2**LEN_W-1.
- ALLOW_US, 1: 1 = '_' (0x5F) counts as a letter; 0 = '_' is an illegal char.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  char is presented this cycle.
- char  in  8  ASCII character.
- eos  in  1  end-of-stream pulse; flushes any open token.
- tok_valid  out  1  one-cycle pulse: token complete.
- tok_kind  out  2  01 ID, 10 NUM, 11 BAD; 00 when tok_valid=0.
- tok_len  out  LEN_W  token length, saturating at MAX_LEN.
- in_id  out  1  level: chars so far in the open token form a legal identifier.
- id_cnt  out  CNT_W  identifiers emitted, saturating.
- bad_cnt  out  CNT_W  BAD tokens emitted, saturating.

Behaviour:
- Reset is asynchronous, active-low (rst_n=0). Reset values: state=IDLE; tok_valid, tok_kind, tok_len, in_id, id_cnt, bad_cnt all 0.
- Char classes:
  - L: A-Z, a-z, and '_' when ALLOW_US=1.
  - D: 0-9.
  - S (delimiter): 0x20, 0x09, 0x0A, 0x0D, ';'.
  - X: everything else.
- States: IDLE, IDENT, NUMBER, BAD. Transitions apply only when in_valid=1.
- IDLE: L -> IDENT (len=1); D -> NUMBER (len=1); X -> BAD (len=1); S -> IDLE, no output.
- IDENT: L or D -> IDENT; X -> BAD; S -> emit ID, go IDLE.
- NUMBER: D -> NUMBER; L or X -> BAD; S -> emit NUM, go IDLE.
- BAD: L, D or X -> BAD; S -> emit BAD, go IDLE.
- Length:
  - Each non-S char increments len, saturating at MAX_LEN.
  - A non-S char arriving while len==MAX_LEN forces the state to BAD (overlong token); len stays MAX_LEN.
- Emit timing: registered. tok_valid, tok_kind and tok_len are high/valid in the cycle after the delimiter edge, for exactly one cycle. Latency is 1 clk.
- eos:
  - eos=1 with an open token emits it exactly as a delimiter would.
  - eos in IDLE does nothing.
  - eos together with an in_valid non-S char: the char is absorbed first (class and length update), then the token is emitted including that char.
  - eos together with an S char produces a single emit.
- in_id: registered; equals (next state == IDENT). Holds while in_valid=0. Clears in the same edge as the emit.
- Counters:
  - id_cnt increments on each ID emit.
  - bad_cnt increments on each BAD emit.
  - Both saturate at 2**CNT_W-1; NUM emits are not counted.
- in_valid=0: state, len and in_id hold; tok_valid=0.
- Back-to-back tokens: "a b" (S between) yields two emits, 2 cycles apart. Consecutive delimiters yield no empty tokens.
- Reset mid-token discards the token with no emit; counters clear.

Test Plan:
- Basic identifier: chars "abcd1234" then ' ' -> one cycle after the space edge: tok_valid=1, kind=01, len=8, id_cnt=1. in_id=1 from the first char through the last.
- Number, then bad token: "123" ';' -> kind=10, len=3. Then "12a" ' ' -> kind=11, len=3, bad_cnt=1. in_id stays 0 throughout.
- Overlong token (MAX_LEN=16): 17×'x' then ' ' -> kind=11, len=16. in_id drops to 0 after the 17th char.
- Underscore mode: ALLOW_US=1, "_v2" then eos -> kind=01, len=3. ALLOW_US=0, same stimulus -> kind=11, len=3.
- Gaps and simultaneous events: "ab" with in_valid=0 bubbles, then '9' with eos=1 in the same cycle -> kind=01, len=3. Then eos alone -> no pulse. Then "  ;" -> no pulse.
- Reset mid-token: "abc", assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, send ' ' -> no emit.
